// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's FSM state type.
// Also holds the byte-lane decode used for sub-word writes.
package ahb_params_pkg;

    localparam int AHB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BYTE      = 3'b000,
        HALF_WORD = 3'b001,
        WORD      = 3'b010,
        DWORD     = 3'b011,
        LINE4     = 3'b100,
        LINE8     = 3'b101,
        LINE16    = 3'b110,
        LINE32    = 3'b111
    } hsize_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR1 = 2'b10,
        ERR2 = 2'b11
    } state_t;

    // Little-endian lane enables; only called for sizes that passed the legality check.
    function automatic logic [3:0] byte_en(input hsize_t size, input logic [1:0] lsb);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            BYTE:      be = 4'b0001 << lsb;
            HALF_WORD: be = lsb[1] ? 4'b1100 : 4'b0011;
            WORD:      be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM split into four byte lanes, one write enable per lane.
// The read port is combinational so the completing data phase sees the word directly.
module ahb_sram_bank #(
    parameter int  MEM_DEPTH = 1024,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by ahb_sram_bank: wait-state insertion, sub-word
// writes and the two-cycle ERROR response for misaligned, oversized or out-of-range accesses.
module ahb_sram_slave
    import ahb_params_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    htrans_t          trans_in;
    hsize_t           size_in;
    logic             capture;
    logic             misaligned;
    logic             out_of_range;
    logic             illegal;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic             active_reg;
    logic             write_reg;
    hsize_t           size_reg;
    logic [IDX_W+1:0] addr_reg;
    logic             hreadyout_reg;
    hresp_t           hresp_reg;

    logic [3:0]       bank_we;
    logic [31:0]      bank_rdata;
    logic             wr_done;
    logic             rd_done;
    logic             unused_hburst;

    assign trans_in = htrans_t'(HTRANS);
    assign size_in  = hsize_t'(HSIZE);
    assign capture  = HSEL && HREADY && (trans_in == TRANS_NONSEQ || trans_in == TRANS_SEQ);

    assign misaligned   = (size_in == HALF_WORD && HADDR[0]) ||
                          (size_in == WORD && HADDR[1:0] != 2'b00);
    // Depth is a power of two, so any set bit above the word index is out of range.
    assign out_of_range = |(HADDR >> (IDX_W + 2));
    assign illegal      = (HSIZE > 3'(WORD)) || misaligned || out_of_range;

    // Burst type never affects addressing; every beat carries its own HADDR.
    assign unused_hburst = ^HBURST;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            active_reg    <= 1'b0;
            write_reg     <= 1'b0;
            size_reg      <= BYTE;
            addr_reg      <= '0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= OKAY;
        end else begin
            case (state_reg)
                IDLE, ERR2: begin
                    if (capture) begin
                        addr_reg  <= HADDR[IDX_W+1:0];
                        write_reg <= HWRITE;
                        size_reg  <= size_in;
                        if (illegal) begin
                            state_reg     <= ERR1;
                            active_reg    <= 1'b0;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= ERROR;
                        end else begin
                            active_reg <= 1'b1;
                            hresp_reg  <= OKAY;
                            if (WAIT_STATES > 0) begin
                                state_reg     <= WAIT;
                                cnt_reg       <= 4'(WAIT_STATES);
                                hreadyout_reg <= 1'b0;
                            end else begin
                                state_reg     <= IDLE;
                                hreadyout_reg <= 1'b1;
                            end
                        end
                    end else begin
                        state_reg     <= IDLE;
                        active_reg    <= 1'b0;
                        hreadyout_reg <= 1'b1;
                        hresp_reg     <= OKAY;
                    end
                end
                WAIT: begin
                    if (cnt_reg <= 4'd1) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= 4'd0;
                        hreadyout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ERR1: begin
                    state_reg     <= ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= ERROR;
                end
                default: begin
                    state_reg     <= IDLE;
                    active_reg    <= 1'b0;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= OKAY;
                end
            endcase
        end
    end

    // A legal data phase completes in the cycle its registered ready is high.
    assign wr_done = active_reg && write_reg && hreadyout_reg;
    assign rd_done = active_reg && !write_reg && hreadyout_reg;
    assign bank_we = wr_done ? byte_en(size_reg, addr_reg[1:0]) : 4'b0000;

    ahb_sram_bank #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .we    (bank_we),
        .addr  (addr_reg[IDX_W+1:2]),
        .wdata (HWDATA),
        .rdata (bank_rdata)
    );

    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;
    assign HRDATA    = rd_done ? bank_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states and one with two;
// a driver queues expected data-phase responses and a monitor thread pops and compares them.
module tb_ahb_sram_slave;

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          low;
        string       name;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          low;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        use2 = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;

    logic        ready0, ready2, rdy;
    logic [1:0]  resp0, resp2, resp;
    logic [31:0] rdata0, rdata2, rdata;
    logic        sel0, sel2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   cyc_start = 0;
    vec_t seq[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sel0  = hsel && !use2;
    assign sel2  = hsel && use2;
    assign rdy   = use2 ? ready2 : ready0;
    assign resp  = use2 ? resp2 : resp0;
    assign rdata = use2 ? rdata2 : rdata0;

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy),
        .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy),
        .HREADYOUT(ready2), .HRESP(resp2), .HRDATA(rdata2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] t, input logic w, input logic [2:0] s,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] r, input logic [31:0] rd,
                                input int lo, input string nm);
        seq.push_back('{t, w, s, a, wd, r, rd, lo, nm});
    endfunction

    // Returns just after the rising edge at which the current address phase is taken.
    task automatic wait_capture();
        logic r;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            r = rdy;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 50) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL ready_timeout: got ready=0 for %0d cycles, expected ready", n);
                break;
            end
        end
        #1;
    endtask

    task automatic run_seq();
        logic [31:0] prev_wd;
        prev_wd = '0;
        foreach (seq[i]) begin
            hwdata = prev_wd;
            hsel   = 1'b1;
            htrans = seq[i].trans;
            hwrite = seq[i].wr;
            hsize  = seq[i].size;
            haddr  = seq[i].addr;
            if (seq[i].trans[1])
                exp_q.push_back('{seq[i].resp, seq[i].rdata, seq[i].low, seq[i].name});
            prev_wd = seq[i].wdata;
            wait_capture();
            if (i == 0) cyc_start = cyc;
        end
        hwdata = prev_wd;
        htrans = 2'b00;
        wait_capture();
        hsel   = 1'b0;
        hburst = 3'b000;
        seq.delete();
    endtask

    initial begin
        fork
            begin : monitor
                bit   in_dp;
                bit   low_bad;
                int   low;
                exp_t e;
                in_dp = 0; low_bad = 0; low = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        in_dp = 0; low = 0; low_bad = 0;
                        continue;
                    end
                    if (in_dp) begin
                        if (!rdy) begin
                            low++;
                            if (exp_q.size() > 0 && resp !== exp_q[0].resp) low_bad = 1;
                            if (low > 40) begin
                                n_tests++;
                                n_fail++;
                                $display("[TB] FAIL dphase_timeout: got %0d wait cycles, expected completion", low);
                                in_dp = 0; low = 0; low_bad = 0;
                            end
                        end else begin
                            if (exp_q.size() == 0) begin
                                n_tests++;
                                n_fail++;
                                $display("[TB] FAIL unexpected_dphase: got completion, expected none");
                            end else begin
                                e = exp_q.pop_front();
                                $display("[TB] %s resp=%0d rdata=%h waits=%0d", e.name, resp, rdata, low);
                                check({e.name, "_resp"}, 32'(resp), 32'(e.resp));
                                check({e.name, "_rdata"}, rdata, e.rdata);
                                check({e.name, "_waits"}, 32'(low), 32'(e.low));
                                check({e.name, "_waitresp"}, 32'(low_bad), 32'd0);
                            end
                            in_dp = 0; low = 0; low_bad = 0;
                        end
                    end
                    if (hsel && rdy && htrans[1]) in_dp = 1;
                end
            end
        join_none

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready2", 32'(ready2), 32'd1);
        check("rst_resp2", 32'(resp2), 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait instance: word, byte, half-word, errors
        add(2'b10, 1, 3'd2, 32'h10,   32'hDEADBEEF, 2'd0, 32'h0,        0, "w10");
        add(2'b10, 0, 3'd2, 32'h10,   32'h0,        2'd0, 32'hDEADBEEF, 0, "r10a");
        add(2'b10, 1, 3'd2, 32'h10,   32'h11223344, 2'd0, 32'h0,        0, "w10b");
        add(2'b10, 1, 3'd0, 32'h13,   32'hAA5A5A5A, 2'd0, 32'h0,        0, "wb13");
        add(2'b10, 0, 3'd2, 32'h10,   32'h0,        2'd0, 32'hAA223344, 0, "r10b");
        add(2'b10, 1, 3'd1, 32'h10,   32'hFFFF5566, 2'd0, 32'h0,        0, "wh10");
        add(2'b10, 0, 3'd2, 32'h10,   32'h0,        2'd0, 32'hAA225566, 0, "r10c");
        add(2'b01, 0, 3'd2, 32'h14,   32'h0,        2'd0, 32'h0,        0, "busy");
        add(2'b10, 0, 3'd0, 32'h12,   32'h0,        2'd0, 32'hAA225566, 0, "rb12");
        add(2'b10, 0, 3'd2, 32'h02,   32'h0,        2'd1, 32'h0,        1, "rmis");
        add(2'b10, 0, 3'd2, 32'h10,   32'h0,        2'd0, 32'hAA225566, 0, "r10d");
        add(2'b10, 1, 3'd2, 32'h00,   32'h01020304, 2'd0, 32'h0,        0, "w00");
        add(2'b10, 1, 3'd2, 32'h1000, 32'hBAD0BAD0, 2'd1, 32'h0,        1, "woor");
        add(2'b10, 0, 3'd2, 32'h00,   32'h0,        2'd0, 32'h01020304, 0, "r00");
        add(2'b10, 0, 3'd1, 32'h01,   32'h0,        2'd1, 32'h0,        1, "rhmis");
        add(2'b10, 1, 3'd2, 32'h04,   32'h55667788, 2'd0, 32'h0,        0, "w04");
        add(2'b10, 1, 3'd3, 32'h04,   32'hFFFFFFFF, 2'd1, 32'h0,        1, "wsz3");
        add(2'b10, 1, 3'd0, 32'h05,   32'h123499AB, 2'd0, 32'h0,        0, "wb05");
        add(2'b10, 0, 3'd2, 32'h04,   32'h0,        2'd0, 32'h55669988, 0, "r04");
        run_seq();
        repeat (2) @(posedge clk);
        #1;

        // Two-wait-state instance: INCR4 write and read bursts from 0x20
        use2   = 1'b1;
        hburst = 3'b011;
        add(2'b10, 1, 3'd2, 32'h20, 32'hA0A0A0A0, 2'd0, 32'h0, 2, "bw20");
        add(2'b11, 1, 3'd2, 32'h24, 32'hA1A1A1A1, 2'd0, 32'h0, 2, "bw24");
        add(2'b11, 1, 3'd2, 32'h28, 32'hA2A2A2A2, 2'd0, 32'h0, 2, "bw28");
        add(2'b11, 1, 3'd2, 32'h2C, 32'hA3A3A3A3, 2'd0, 32'h0, 2, "bw2c");
        run_seq();
        check("incr4_wr_cycles", 32'(cyc - cyc_start), 32'd12);
        hburst = 3'b011;
        add(2'b10, 0, 3'd2, 32'h20, 32'h0, 2'd0, 32'hA0A0A0A0, 2, "br20");
        add(2'b11, 0, 3'd2, 32'h24, 32'h0, 2'd0, 32'hA1A1A1A1, 2, "br24");
        add(2'b11, 0, 3'd2, 32'h28, 32'h0, 2'd0, 32'hA2A2A2A2, 2, "br28");
        add(2'b11, 0, 3'd2, 32'h2C, 32'h0, 2'd0, 32'hA3A3A3A3, 2, "br2c");
        run_seq();
        check("incr4_rd_cycles", 32'(cyc - cyc_start), 32'd12);
        add(2'b10, 0, 3'd2, 32'h22, 32'h0,        2'd1, 32'h0, 1, "rmis2");
        add(2'b10, 1, 3'd2, 32'h30, 32'h12345678, 2'd0, 32'h0, 2, "w30");
        run_seq();
        repeat (2) @(posedge clk);
        #1;

        // Reset while a write sits in its wait states
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
        wait_capture();
        hwdata = 32'hCAFEF00D; htrans = 2'b00; hsel = 1'b0;
        check("prereset_ready", 32'(rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy), 32'd1);
        check("midrst_resp", 32'(resp), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        add(2'b10, 0, 3'd2, 32'h30, 32'h0, 2'd0, 32'h12345678, 2, "r30");
        run_seq();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB responder that answers the transfers issued by the system's AHB initiators and backs them with an on-chip word-organised SRAM. It sits behind the address decoder on one HSEL line and returns HREADYOUT, HRESP and HRDATA to the slave-to-master multiplexer. It supports configurable wait states, byte/half-word/word accesses, and the two-cycle ERROR response for illegal accesses. RETRY and SPLIT are never issued.

## Interface
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 1024, SRAM depth in 32-bit words; must be a power of 2.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0–15.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  htrans_t.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  hsize_t.
- HBURST  in  3  hburst_t; accepted but not used for address generation.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; the previous data phase is ending.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  hresp_t; only OKAY or ERROR.
- HRDATA  out  DATA_WIDTH  read data.

## Operation
- **Address-phase capture:** the address phase is captured when HSEL && HREADY && HTRANS ∈ {NONSEQ, SEQ}. The captured fields are addr_q, write_q, size_q, and a flag for a legal or illegal transfer.
- **IDLE and BUSY:** with HSEL high and HREADY high, these produce no captured transfer. The next data phase is zero-wait OKAY.
- **Illegal transfer**, any of the following:
  - HSIZE > WORD;
  - misalignment: HSIZE = HALF_WORD with HADDR[0] = 1, or HSIZE = WORD with HADDR[1:0] ≠ 0;
  - word index HADDR[ADDR_WIDTH-1:2] ≥ MEM_DEPTH.
- **State machine (state_t):** IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT: legal capture and WAIT_STATES > 0. A down-counter is loaded with WAIT_STATES.
  - IDLE → ERR1: illegal capture.
  - IDLE stays IDLE: legal capture and WAIT_STATES = 0. The data phase completes immediately.
  - WAIT: HREADYOUT = 0 and the counter decrements. When the counter reaches 1, the next cycle has HREADYOUT = 1 and the FSM accepts the next capture, exactly as in IDLE.
  - ERR1: HREADYOUT = 0, HRESP = ERROR. Always → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = ERROR. New captures are accepted as in IDLE.
- **Write:** the write commits on the cycle where the data phase completes (HREADYOUT = 1, OKAY).
  - Byte enables: BYTE → lane addr_q[1:0]; HALF_WORD → lanes {addr_q[1], 0} and {addr_q[1], 1}; WORD → all four lanes.
  - Little-endian lane mapping.
- **Read:**
  - HRDATA = full 32-bit word mem[addr_q[..:2]] whenever the completing data phase is a legal read.
  - HRDATA = 0 otherwise, including on ERROR.
  - Sub-word lanes are not zeroed; the master selects the lanes it needs.
- **Erroring writes:** a write that errors never modifies memory.
- **Memory contents:** not cleared by reset.

## Timing
- **Reset values (asynchronous, while HRESETn is low):** HREADYOUT = 1, HRESP = OKAY, HRDATA = 0, state = IDLE, counter = 0, capture flags cleared.
- **Latency:**
  - Read and write data phase = 1 + WAIT_STATES cycles.
  - Error data phase = exactly 2 cycles.
- **Back-to-back transfers:** a read following a write to the same word returns the new data. The write commits at the end of its data phase, before the read's data phase.
- **Address-phase fields:** address-phase inputs are ignored while HREADY = 0. The master must hold them stable, and only the cycle with HREADY = 1 is captured.
- **Deselect mid-burst:** HSEL dropping mid-burst still completes the already-captured data phase normally.
- **Reset mid-transfer:**
  - The transfer is abandoned and no write commits.
  - Outputs return to reset values immediately.
  - The first capture happens after HRESETn is released.

## Structure
- Add `state_t` for the slave FSM to ahb_params_pkg.
- Reuse `htrans_t`, `hsize_t` and `hresp_t` from ahb_params_pkg.
- Sub-module `ahb_sram_bank`: a MEM_DEPTH×32 array with a 4-bit byte write-enable and an asynchronous read port. The FSM and address/size decode stay in ahb_sram_slave.

## Test plan
- **Word write then read, WAIT_STATES = 0:** write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA = 0xDEADBEEF; HREADYOUT stays 1 throughout; HRESP = OKAY.
- **Byte write:** write byte 0xAA at 0x13 over word 0x11223344 at 0x10 → word reads 0xAA223344. Then write half-word 0x5566 at 0x10 → word reads 0xAA225566.
- **Wait states, WAIT_STATES = 2:** each data phase holds HREADYOUT = 0 for exactly 2 cycles. An INCR4 burst from 0x20 completes in 12 cycles after the first address phase.
- **Misalignment:** WORD read at 0x02 → one cycle HREADYOUT = 0/ERROR, then one cycle HREADYOUT = 1/ERROR. HRDATA = 0, and the following legal read returns OKAY.
- **Out-of-range write:** WORD write to 4·MEM_DEPTH → ERROR pair. A read of word 0 shows its value unchanged.
- **Async reset mid-transfer:** assert HRESETn = 0 during the WAIT state of a write → HREADYOUT = 1, HRESP = OKAY and HRDATA = 0 immediately. The target word is unchanged after release.
